operand_stage: RTL and testbench

//  Issue stage directly upstream of alu: holds the integer register file, reads rs1/rs2 operands,

---
 rtl/operand_stage_if.sv | 39 +++
 rtl/operand_stage.sv | 117 +++++++++++
 tb/tb_operand_stage.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_stage_if.sv
// Issue-stage bundle: decoded-instruction input, ALU operand output, write-back return and flush.
// The master side belongs to decode/ALU/write-back, the slave side to operand_stage.
interface operand_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            id_valid;
    logic            id_ready;
    logic [AW-1:0]   id_rs1_addr;
    logic [AW-1:0]   id_rs2_addr;
    logic [AW-1:0]   id_rd_addr;
    logic            id_rd_wen;
    logic            id_use_imm;
    logic [XLEN-1:0] id_imm;
    logic [2:0]      id_ctrl;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic [2:0]      ctrl;
    logic [AW-1:0]   ex_rd_addr;
    logic            ex_rd_wen;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;

    modport master (
        output id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_wen, id_use_imm, id_imm,
               id_ctrl, ex_ready, wb_en, wb_addr, wb_data, flush,
        input  id_ready, ex_valid, rs1, rs2, ctrl, ex_rd_addr, ex_rd_wen
    );

    modport slave (
        input  id_valid, id_rs1_addr, id_rs2_addr, id_rd_addr, id_rd_wen, id_use_imm, id_imm,
               id_ctrl, ex_ready, wb_en, wb_addr, wb_data, flush,
        output id_ready, ex_valid, rs1, rs2, ctrl, ex_rd_addr, ex_rd_wen
    );
endinterface

// File: rtl/operand_stage.sv
// Operand issue stage: register file, pending-write scoreboard and ID/EX register feeding the ALU.
// Define OPERAND_STAGE_BYPASS_EN to forward same-cycle write-back data into the issuing operand.
module operand_stage #(
    parameter int XLEN = 32,
    parameter int REGS = 32,
    parameter int AW   = $clog2(REGS)
) (
    input  logic           clk,
    input  logic           rst_n,
    operand_stage_if.slave bus
);

    logic [XLEN-1:0] regs [REGS];
    logic [REGS-1:0] pending;
    logic [REGS-1:0] pending_nxt;

    logic            rs1_fwd;
    logic            rs2_fwd;
    logic            rs1_haz;
    logic            rs2_haz;
    logic            waw_haz;
    logic            hazard;
    logic            accept;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;

`ifdef OPERAND_STAGE_BYPASS_EN
    assign rs1_fwd = bus.wb_en && (bus.wb_addr == bus.id_rs1_addr);
    assign rs2_fwd = bus.wb_en && (bus.wb_addr == bus.id_rs2_addr);
`else
    assign rs1_fwd = 1'b0;
    assign rs2_fwd = 1'b0;
`endif

    // A forwarded source is no longer a hazard; the destination check never forwards.
    always_comb begin
        rs1_haz = (bus.id_rs1_addr != '0) && pending[bus.id_rs1_addr] && !rs1_fwd;
        rs2_haz = !bus.id_use_imm && (bus.id_rs2_addr != '0) && pending[bus.id_rs2_addr] && !rs2_fwd;
        waw_haz = bus.id_rd_wen && (bus.id_rd_addr != '0) && pending[bus.id_rd_addr];
    end

    assign hazard       = rs1_haz || rs2_haz || waw_haz;
    assign bus.id_ready = (!bus.ex_valid || bus.ex_ready) && !hazard && !bus.flush;
    assign accept       = bus.id_valid && bus.id_ready;

    always_comb begin
        rs1_val = '0;
        if (bus.id_rs1_addr != '0) begin
            rs1_val = rs1_fwd ? bus.wb_data : regs[bus.id_rs1_addr];
        end
    end

    always_comb begin
        rs2_val = '0;
        if (bus.id_use_imm) begin
            rs2_val = bus.id_imm;
        end else if (bus.id_rs2_addr != '0) begin
            rs2_val = rs2_fwd ? bus.wb_data : regs[bus.id_rs2_addr];
        end
    end

    // Clears first, then the accept set, so a same-index set wins over write-back.
    always_comb begin
        pending_nxt = pending;
        if (bus.wb_en) begin
            pending_nxt[bus.wb_addr] = 1'b0;
        end
        if (bus.flush && bus.ex_valid && bus.ex_rd_wen && (bus.ex_rd_addr != '0)) begin
            pending_nxt[bus.ex_rd_addr] = 1'b0;
        end
        if (accept && bus.id_rd_wen && (bus.id_rd_addr != '0)) begin
            pending_nxt[bus.id_rd_addr] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (bus.wb_en && (bus.wb_addr != '0)) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.ex_valid   <= 1'b0;
            bus.rs1        <= '0;
            bus.rs2        <= '0;
            bus.ctrl       <= '0;
            bus.ex_rd_addr <= '0;
            bus.ex_rd_wen  <= 1'b0;
        end else if (bus.flush) begin
            bus.ex_valid <= 1'b0;
        end else if (accept) begin
            bus.ex_valid   <= 1'b1;
            bus.rs1        <= rs1_val;
            bus.rs2        <= rs2_val;
            bus.ctrl       <= bus.id_ctrl;
            bus.ex_rd_addr <= bus.id_rd_addr;
            bus.ex_rd_wen  <= bus.id_rd_wen;
        end else if (bus.ex_ready) begin
            bus.ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: a register model supplies expected operands, which are queued
// at issue and popped when the ID/EX register presents them.
module tb_operand_stage;

    logic clk;
    logic rst_n;

    operand_stage_if #(.XLEN(32), .AW(5)) bus ();

    operand_stage #(.XLEN(32), .REGS(32), .AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs [32];
    int          vectors;
    int          miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c,
                        input logic [4:0] rd, input logic wen);
        exp_t e;
        e.a = a; e.b = b; e.c = c; e.rd = rd; e.wen = wen;
        q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'd1);
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s.queue observed=empty expected=entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, ".rs1"}, bus.rs1, e.a);
            chk({tag, ".rs2"}, bus.rs2, e.b);
            chk({tag, ".ctrl"}, 32'(bus.ctrl), 32'(e.c));
            chk({tag, ".rd"}, 32'(bus.ex_rd_addr), 32'(e.rd));
            chk({tag, ".wen"}, 32'(bus.ex_rd_wen), 32'(e.wen));
        end
    endtask

    task automatic issue(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                         input logic wen, input logic uimm, input logic [31:0] imm,
                         input logic [2:0] c);
        bus.id_valid    = 1'b1;
        bus.id_rs1_addr = a1;
        bus.id_rs2_addr = a2;
        bus.id_rd_addr  = rd;
        bus.id_rd_wen   = wen;
        bus.id_use_imm  = uimm;
        bus.id_imm      = imm;
        bus.id_ctrl     = c;
    endtask

    task automatic wb(input logic [4:0] addr, input logic [31:0] data);
        bus.wb_en   = 1'b1;
        bus.wb_addr = addr;
        bus.wb_data = data;
        if (addr != 5'd0) mregs[addr] = data;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_reset();
        rst_n           = 1'b0;
        bus.id_valid    = 1'b0;
        bus.id_rs1_addr = '0;
        bus.id_rs2_addr = '0;
        bus.id_rd_addr  = '0;
        bus.id_rd_wen   = 1'b0;
        bus.id_use_imm  = 1'b0;
        bus.id_imm      = '0;
        bus.id_ctrl     = '0;
        bus.ex_ready    = 1'b1;
        bus.wb_en       = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        bus.flush       = 1'b0;

        // Reset values
        #3;
        chk("rst.ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst.rs1", bus.rs1, 32'd0);
        chk("rst.rs2", bus.rs2, 32'd0);
        chk("rst.ctrl", 32'(bus.ctrl), 32'd0);
        chk("rst.rd", 32'(bus.ex_rd_addr), 32'd0);
        chk("rst.wen", 32'(bus.ex_rd_wen), 32'd0);
        tick();
        rst_n = 1'b1;
        settle();
        chk("rst.id_ready", 32'(bus.id_ready), 32'd1);

        // Basic issue of x5, x6 into rd=7
        wb(5'd5, 32'd20);
        tick();
        wb(5'd6, 32'd30);
        tick();
        bus.wb_en = 1'b0;
        issue(5'd5, 5'd6, 5'd7, 1'b1, 1'b0, 32'd0, 3'b000);
        settle();
        chk("t1.id_ready", 32'(bus.id_ready), 32'd1);
        push(mregs[5], mregs[6], 3'b000, 5'd7, 1'b1);
        tick();
        pop_check("t1");

        // RAW on x7 until write-back
        issue(5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 32'd0, 3'b001);
        settle();
        chk("t2.stall0", 32'(bus.id_ready), 32'd0);
        tick();
        chk("t2.stall1", 32'(bus.id_ready), 32'd0);
        wb(5'd7, 32'd50);
        settle();
`ifdef OPERAND_STAGE_BYPASS_EN
        chk("t2.bypass_ready", 32'(bus.id_ready), 32'd1);
        push(32'd50, 32'd0, 3'b001, 5'd8, 1'b1);
        tick();
        bus.wb_en = 1'b0;
`else
        chk("t2.wb_cycle_stall", 32'(bus.id_ready), 32'd0);
        tick();
        bus.wb_en = 1'b0;
        settle();
        chk("t2.after_wb_ready", 32'(bus.id_ready), 32'd1);
        push(32'd50, 32'd0, 3'b001, 5'd8, 1'b1);
        tick();
`endif
        pop_check("t2");
        bus.id_valid = 1'b0;

        // x0 write ignored; immediate ignores pending rs2 (x8)
        wb(5'd0, 32'hFFFF_FFFF);
        tick();
        bus.wb_en = 1'b0;
        issue(5'd0, 5'd8, 5'd0, 1'b1, 1'b1, 32'hFFFF_FFFD, 3'b010);
        settle();
        chk("t3.id_ready", 32'(bus.id_ready), 32'd1);
        push(32'd0, 32'hFFFF_FFFD, 3'b010, 5'd0, 1'b1);
        tick();
        pop_check("t3");
        bus.id_valid = 1'b0;
        wb(5'd8, 32'd80);
        tick();
        bus.wb_en = 1'b0;

        // Back-pressure: hold for three cycles, then back-to-back load
        issue(5'd5, 5'd6, 5'd10, 1'b0, 1'b0, 32'd0, 3'b011);
        push(mregs[5], mregs[6], 3'b011, 5'd10, 1'b0);
        tick();
        pop_check("t4a");
        bus.ex_ready = 1'b0;
        issue(5'd6, 5'd0, 5'd11, 1'b0, 1'b1, 32'd7, 3'b100);
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("t4.hold_ready", 32'(bus.id_ready), 32'd0);
            tick();
            chk("t4.hold_rs1", bus.rs1, mregs[5]);
            chk("t4.hold_rs2", bus.rs2, mregs[6]);
            chk("t4.hold_ctrl", 32'(bus.ctrl), 32'd3);
        end
        bus.ex_ready = 1'b1;
        settle();
        chk("t4.release_ready", 32'(bus.id_ready), 32'd1);
        push(mregs[6], 32'd7, 3'b100, 5'd11, 1'b0);
        tick();
        pop_check("t4b");
        bus.id_valid = 1'b0;
        tick();

        // Flush of pending writer x9 frees its dependent
        bus.ex_ready = 1'b0;
        issue(5'd5, 5'd6, 5'd9, 1'b1, 1'b0, 32'd0, 3'b101);
        push(mregs[5], mregs[6], 3'b101, 5'd9, 1'b1);
        tick();
        pop_check("t5a");
        issue(5'd9, 5'd5, 5'd12, 1'b0, 1'b0, 32'd0, 3'b110);
        settle();
        chk("t5.raw_stall", 32'(bus.id_ready), 32'd0);
        bus.flush = 1'b1;
        settle();
        chk("t5.flush_ready", 32'(bus.id_ready), 32'd0);
        tick();
        bus.flush = 1'b0;
        chk("t5.flushed_valid", 32'(bus.ex_valid), 32'd0);
        bus.ex_ready = 1'b1;
        settle();
        chk("t5.dep_ready", 32'(bus.id_ready), 32'd1);
        push(mregs[9], mregs[5], 3'b110, 5'd12, 1'b0);
        tick();
        pop_check("t5b");
        bus.id_valid = 1'b0;
        tick();

        // Same-cycle accept and write-back of x4: set wins, WAW then stalls
        issue(5'd5, 5'd6, 5'd4, 1'b1, 1'b0, 32'd0, 3'b111);
        wb(5'd4, 32'd44);
        settle();
        chk("t6.id_ready", 32'(bus.id_ready), 32'd1);
        push(mregs[5], mregs[6], 3'b111, 5'd4, 1'b1);
        tick();
        bus.wb_en = 1'b0;
        pop_check("t6a");
        issue(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'd0, 3'b001);
        wb(5'd4, 32'd99);
        settle();
        chk("t6.waw_stall", 32'(bus.id_ready), 32'd0);
        tick();
        bus.wb_en = 1'b0;
        settle();
        chk("t6.waw_clear", 32'(bus.id_ready), 32'd1);
        push(32'd0, 32'd0, 3'b001, 5'd4, 1'b1);
        tick();
        pop_check("t6b");
        bus.id_valid = 1'b0;

        // Reset with x4 pending; later write-back still lands
        rst_n = 1'b0;
        model_reset();
        settle();
        chk("t7.rst_valid", 32'(bus.ex_valid), 32'd0);
        chk("t7.rst_rs1", bus.rs1, 32'd0);
        rst_n = 1'b1;
        issue(5'd5, 5'd6, 5'd4, 1'b1, 1'b0, 32'd0, 3'b010);
        settle();
        chk("t7.ready_after_rst", 32'(bus.id_ready), 32'd1);
        push(mregs[5], mregs[6], 3'b010, 5'd4, 1'b1);
        tick();
        pop_check("t7a");
        bus.id_valid = 1'b0;
        wb(5'd4, 32'd77);
        tick();
        bus.wb_en = 1'b0;
        issue(5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 32'd0, 3'b011);
        settle();
        chk("t7.read_ready", 32'(bus.id_ready), 32'd1);
        push(mregs[4], 32'd0, 3'b011, 5'd0, 1'b0);
        tick();
        pop_check("t7b");
        bus.id_valid = 1'b0;
        tick();
        chk("end.drained", 32'(bus.ex_valid), 32'd0);
        chk("end.queue", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
